display_timing_gen: RTL and testbench



---
 rtl/display_timing_gen.sv | 155 +++++++++++++++
 tb/tb_display_timing_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, active-area flag
// and sync outputs, each delay-matched to the downstream pixel pipeline.
module display_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int VID_DLY  = 1,
    parameter int SYNC_DLY = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_row,
    output logic [9:0] pixel_column,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_E  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_E  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_frame_start;
    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_act;
    logic       w_hs;
    logic       w_vs;
    logic       w_vid_dly;
    logic       w_hs_dly;
    logic       w_vs_dly;

    // Pixel-tick divider; collapses to a constant tick when no division is needed.
    generate
        if (CLK_DIV <= 1) begin : g_nodiv
            assign w_tick = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] r_div;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_div <= '0;
                end else if (r_div == DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_tick = (r_div == DIV_LAST);
        end
    endgenerate

    assign w_h_wrap = w_tick && (r_hc == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_vc == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
            if (w_tick) begin
                r_hc <= w_h_wrap ? 10'd0 : r_hc + 10'd1;
            end
            if (w_h_wrap) begin
                r_vc <= w_v_wrap ? 10'd0 : r_vc + 10'd1;
            end
        end
    end

    assign w_act = (r_hc < H_ACT_E) && (r_vc < V_ACT_E);
    assign w_hs  = (r_hc >= H_SYNC_S) && (r_hc < H_SYNC_E);
    assign w_vs  = (r_vc >= V_SYNC_S) && (r_vc < V_SYNC_E);

    // video_on delay: matches the world-map read latency.
    generate
        if (VID_DLY == 0) begin : g_vid_nodly
            assign w_vid_dly = w_act;
        end else begin : g_vid_dly
            logic [VID_DLY-1:0] r_vid_pipe;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vid_pipe <= '0;
                end else begin
                    r_vid_pipe[0] <= w_act;
                    for (int i = 1; i < VID_DLY; i++) begin
                        r_vid_pipe[i] <= r_vid_pipe[i-1];
                    end
                end
            end

            assign w_vid_dly = r_vid_pipe[VID_DLY-1];
        end
    endgenerate

    // Sync delay: map read plus the colorizer's output register.
    generate
        if (SYNC_DLY == 0) begin : g_sync_nodly
            assign w_hs_dly = w_hs;
            assign w_vs_dly = w_vs;
        end else begin : g_sync_dly
            logic [SYNC_DLY-1:0] r_hs_pipe;
            logic [SYNC_DLY-1:0] r_vs_pipe;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_hs_pipe <= '0;
                    r_vs_pipe <= '0;
                end else begin
                    r_hs_pipe[0] <= w_hs;
                    r_vs_pipe[0] <= w_vs;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign w_hs_dly = r_hs_pipe[SYNC_DLY-1];
            assign w_vs_dly = r_vs_pipe[SYNC_DLY-1];
        end
    endgenerate

    assign pixel_row    = r_vc;
    assign pixel_column = r_hc;
    assign video_on     = w_vid_dly;
    assign horiz_sync   = w_hs_dly ? SYNC_POL : ~SYNC_POL;
    assign vert_sync    = w_vs_dly ? SYNC_POL : ~SYNC_POL;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: two reduced-geometry instances (divided and undivided
// pixel clock) checked every cycle against a closed-form raster model, plus table vectors.
module tb_display_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int TOT = HT * VT;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       fs;
    } outs_t;

    typedef struct {
        int    k;
        outs_t a;
        outs_t b;
    } sb_t;

    typedef struct {
        bit    inst;
        int    k;
        outs_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] a_row, a_col, b_row, b_col;
    logic       a_vid, a_hs, a_vs, a_fs;
    logic       b_vid, b_hs, b_vs, b_fs;

    int  checks = 0;
    int  errors = 0;
    int  k = 0;
    int  fs_cnt_a = 0;
    int  fs_cnt_b = 0;
    sb_t sbq[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .CLK_DIV(3), .VID_DLY(1), .SYNC_DLY(2)
    ) dut_a (
        .clk(clk), .reset(rst), .pixel_row(a_row), .pixel_column(a_col),
        .video_on(a_vid), .horiz_sync(a_hs), .vert_sync(a_vs), .frame_start(a_fs)
    );

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .CLK_DIV(1), .VID_DLY(1), .SYNC_DLY(0)
    ) dut_b (
        .clk(clk), .reset(rst), .pixel_row(b_row), .pixel_column(b_col),
        .video_on(b_vid), .horiz_sync(b_hs), .vert_sync(b_vs), .frame_start(b_fs)
    );

    // Raster position (in ticks) after k clk edges since reset release.
    function automatic int pos(int kk, int d);
        return (kk / d) % TOT;
    endfunction

    function automatic bit act_f(int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic bit hs_f(int p);
        return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
    endfunction

    function automatic bit vs_f(int p);
        return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
    endfunction

    function automatic outs_t model(int kk, int d, int vd, int sd, bit pol);
        outs_t o;
        int p;
        bit h, v;
        p     = pos(kk, d);
        o.row = 10'(p / HT);
        o.col = 10'(p % HT);
        if (vd == 0)      o.vid = act_f(p);
        else if (kk < vd) o.vid = 1'b0;
        else              o.vid = act_f(pos(kk - vd, d));
        if (sd == 0) begin
            h = hs_f(p);
            v = vs_f(p);
        end else if (kk < sd) begin
            h = 1'b0;
            v = 1'b0;
        end else begin
            h = hs_f(pos(kk - sd, d));
            v = vs_f(pos(kk - sd, d));
        end
        o.hs = h ? pol : ~pol;
        o.vs = v ? pol : ~pol;
        o.fs = (kk > 0) && (kk % d == 0) && ((kk / d) % TOT == 0);
        return o;
    endfunction

    function automatic vec_t mkv(bit inst, int kk, int r, int c, bit vid, bit h, bit v, bit f);
        vec_t x;
        x.inst = inst;
        x.k    = kk;
        x.o    = '{row: 10'(r), col: 10'(c), vid: vid, hs: h, vs: v, fs: f};
        return x;
    endfunction

    // Scoreboard producer: one expected record per clk edge.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            if (rst) k = 0;
            else     k = k + 1;
            e.k = k;
            e.a = model(k, 3, 1, 2, 1'b0);
            e.b = model(k, 1, 1, 0, 1'b1);
            sbq.push_back(e);
        end
    end

    // Scoreboard consumer: compare away from the active edge.
    initial begin
        sb_t   e;
        outs_t ga, gb, gv;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e  = sbq.pop_front();
                ga = '{row: a_row, col: a_col, vid: a_vid, hs: a_hs, vs: a_vs, fs: a_fs};
                gb = '{row: b_row, col: b_col, vid: b_vid, hs: b_hs, vs: b_vs, fs: b_fs};
                fs_cnt_a = fs_cnt_a + int'(a_fs);
                fs_cnt_b = fs_cnt_b + int'(b_fs);
                checks = checks + 2;
                if (ga !== e.a) begin
                    errors++;
                    $display("FAIL sb_a k=%0d got %h exp %h", e.k, ga, e.a);
                end
                if (gb !== e.b) begin
                    errors++;
                    $display("FAIL sb_b k=%0d got %h exp %h", e.k, gb, e.b);
                end
                foreach (vecs[i]) begin
                    if (vecs[i].k == e.k) begin
                        gv = vecs[i].inst ? gb : ga;
                        checks++;
                        if (gv !== vecs[i].o) begin
                            errors++;
                            $display("FAIL vec%0d inst=%0d k=%0d got %h exp %h",
                                     i, vecs[i].inst, e.k, gv, vecs[i].o);
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_now(string tag);
        outs_t ga, gb;
        ga = '{row: a_row, col: a_col, vid: a_vid, hs: a_hs, vs: a_vs, fs: a_fs};
        gb = '{row: b_row, col: b_col, vid: b_vid, hs: b_hs, vs: b_vs, fs: b_fs};
        checks = checks + 2;
        if (ga !== outs_t'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0})) begin
            errors++;
            $display("FAIL %s_a got %h exp reset values", tag, ga);
        end
        if (gb !== outs_t'({10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0})) begin
            errors++;
            $display("FAIL %s_b got %h exp reset values", tag, gb);
        end
    endtask

    initial begin
        int guard;
        // Hand-derived checkpoints: inst 0 = CLK_DIV 3, active-low, SYNC_DLY 2.
        vecs.push_back(mkv(0,   0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mkv(0,   1, 0,  0, 1, 1, 1, 0));
        vecs.push_back(mkv(0,   3, 0,  1, 1, 1, 1, 0));
        vecs.push_back(mkv(0,  30, 0, 10, 0, 1, 1, 0));
        vecs.push_back(mkv(0,  32, 0, 10, 0, 0, 1, 0));
        vecs.push_back(mkv(0,  39, 0, 13, 0, 0, 1, 0));
        vecs.push_back(mkv(0,  41, 0, 13, 0, 1, 1, 0));
        vecs.push_back(mkv(0,  45, 1,  0, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 225, 5,  0, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 227, 5,  0, 0, 1, 0, 0));
        vecs.push_back(mkv(0, 315, 7,  0, 0, 1, 0, 0));
        vecs.push_back(mkv(0, 317, 7,  0, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 360, 0,  0, 0, 1, 1, 1));
        vecs.push_back(mkv(0, 361, 0,  0, 1, 1, 1, 0));
        // inst 1 = CLK_DIV 1, active-high, SYNC_DLY 0.
        vecs.push_back(mkv(1,   1, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mkv(1,  10, 0, 10, 0, 1, 0, 0));
        vecs.push_back(mkv(1,  76, 5,  1, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 120, 0,  0, 0, 0, 0, 1));

        repeat (3) @(negedge clk);
        #1 check_reset_now("rst_hold");
        @(negedge clk);
        #1 rst = 1'b0;
        fs_cnt_a = 0;
        fs_cnt_b = 0;

        // Three full frames of the divided instance: one pulse per frame wrap.
        repeat (3 * TOT * 3 + 20) @(negedge clk);
        #1;
        checks = checks + 2;
        if (fs_cnt_a != 3) begin
            errors++;
            $display("FAIL fs_count_a got %0d exp 3", fs_cnt_a);
        end
        if (fs_cnt_b != 9) begin
            errors++;
            $display("FAIL fs_count_b got %0d exp 9", fs_cnt_b);
        end

        // Async reset mid-line (hc=6, vc=2 on the divided instance), away from any edge.
        guard = 0;
        while ((k % (3 * TOT)) != 110 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL midline_wait timed out after %0d cycles", guard);
        end
        #2 rst = 1'b1;
        #1 check_reset_now("async_rst");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        repeat (400) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
